// File: rtl/shift_unit_seq.sv
// Sequential shifter: one bit position per clock for SLL/SRL/SRA/ROR/ROL.
// It uses a start/done handshake; busy covers the SHIFT and DONE states.
module shift_unit_seq #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] data_in,
    input  logic [AMT_W-1:0] shift_amt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [2:0] OP_SLL = 3'd0;
    localparam logic [2:0] OP_SRL = 3'd1;
    localparam logic [2:0] OP_SRA = 3'd2;
    localparam logic [2:0] OP_ROR = 3'd3;
    localparam logic [2:0] OP_ROL = 3'd4;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    result_d = data_in;
                    op_d     = op;
                    cnt_d    = shift_amt;
                    // Zero count and the pass-through codes skip straight to DONE.
                    if (shift_amt == '0 || op > OP_ROL) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                case (op_q)
                    OP_SLL:  result_d = {result_q[WIDTH-2:0], 1'b0};
                    OP_SRL:  result_d = {1'b0, result_q[WIDTH-1:1]};
                    OP_SRA:  result_d = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
                    OP_ROR:  result_d = {result_q[0], result_q[WIDTH-1:1]};
                    OP_ROL:  result_d = {result_q[WIDTH-2:0], result_q[WIDTH-1]};
                    default: result_d = result_q;
                endcase
                cnt_d = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy   = (state_q == S_SHIFT) || (state_q == S_DONE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Directed self-checking bench for shift_unit_seq.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_shift_unit_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] data_in;
    logic [4:0]  shift_amt;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    shift_unit_seq #(.WIDTH(32), .AMT_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .data_in   (data_in),
        .shift_amt (shift_amt),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation, scramble inputs after acceptance, and measure it.
    task automatic run_op(input logic [2:0] o, input logic [31:0] d, input logic [4:0] a,
                          output logic [31:0] res, output int lat, output int bc);
        start = 1'b1; op = o; data_in = d; shift_amt = a;
        tick();
        start = 1'b0; op = 3'd5; data_in = 32'hA5A5_5A5A; shift_amt = 5'd17;
        lat = 1;
        bc  = (busy === 1'b1) ? 1 : 0;
        while (done !== 1'b1 && lat < 64) begin
            tick();
            lat++;
            if (busy === 1'b1) bc++;
        end
        res = result;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = 3'd0; data_in = '0; shift_amt = '0;
        tick(); tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result got %h want 00000000", result); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_sll();
        logic [31:0] r; int lat, bc;
        run_op(3'd0, 32'h0000_0001, 5'd4, r, lat, bc);
        n_checks++; if (r !== 32'h0000_0010) begin n_fail++; $display("FAIL sll_result got %h want 00000010", r); end
        n_checks++; if (lat != 5) begin n_fail++; $display("FAIL sll_latency got %0d want 5", lat); end
        n_checks++; if (bc != 5) begin n_fail++; $display("FAIL sll_busy_cycles got %0d want 5", bc); end
        tick();
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL sll_idle_after got busy=%b done=%b want 0 0", busy, done); end
        tick(); tick();
        n_checks++; if (result !== 32'h0000_0010) begin n_fail++; $display("FAIL sll_hold got %h want 00000010", result); end
    endtask

    task automatic test_sra_srl();
        logic [31:0] r; int lat, bc;
        run_op(3'd2, 32'h8000_0000, 5'd31, r, lat, bc);
        n_checks++; if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sra_result got %h want ffffffff", r); end
        n_checks++; if (lat != 32) begin n_fail++; $display("FAIL sra_latency got %0d want 32", lat); end
        tick();
        run_op(3'd1, 32'h8000_0000, 5'd31, r, lat, bc);
        n_checks++; if (r !== 32'h0000_0001) begin n_fail++; $display("FAIL srl_result got %h want 00000001", r); end
        n_checks++; if (lat != 32) begin n_fail++; $display("FAIL srl_latency got %0d want 32", lat); end
        tick();
    endtask

    task automatic test_rotate();
        logic [31:0] r; int lat, bc;
        run_op(3'd3, 32'h0000_0001, 5'd1, r, lat, bc);
        n_checks++; if (r !== 32'h8000_0000) begin n_fail++; $display("FAIL ror_result got %h want 80000000", r); end
        n_checks++; if (lat != 2) begin n_fail++; $display("FAIL ror_latency got %0d want 2", lat); end
        tick();
        run_op(3'd4, 32'h8000_0001, 5'd4, r, lat, bc);
        n_checks++; if (r !== 32'h0000_0018) begin n_fail++; $display("FAIL rol_result got %h want 00000018", r); end
        n_checks++; if (lat != 5) begin n_fail++; $display("FAIL rol_latency got %0d want 5", lat); end
        tick();
    endtask

    task automatic test_zero_and_pass();
        logic [31:0] r; int lat, bc;
        run_op(3'd0, 32'hDEAD_BEEF, 5'd0, r, lat, bc);
        n_checks++; if (r !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL zero_amt_result got %h want deadbeef", r); end
        n_checks++; if (lat != 1) begin n_fail++; $display("FAIL zero_amt_latency got %0d want 1", lat); end
        tick();
        run_op(3'd7, 32'h1234_5678, 5'd9, r, lat, bc);
        n_checks++; if (r !== 32'h1234_5678) begin n_fail++; $display("FAIL pass_result got %h want 12345678", r); end
        n_checks++; if (lat != 1) begin n_fail++; $display("FAIL pass_latency got %0d want 1", lat); end
        n_checks++; if (bc != 1) begin n_fail++; $display("FAIL pass_busy_cycles got %0d want 1", bc); end
        tick();
    endtask

    task automatic test_ignored_start();
        int lat;
        start = 1'b1; op = 3'd0; data_in = 32'h0000_0001; shift_amt = 5'd8;
        tick();
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 64) begin
            if (lat == 3) begin
                start = 1'b1; op = 3'd1; data_in = 32'hFFFF_0000; shift_amt = 5'd3;
            end else begin
                start = 1'b0;
            end
            tick();
            lat++;
        end
        start = 1'b0;
        n_checks++; if (lat != 9) begin n_fail++; $display("FAIL ign_latency got %0d want 9", lat); end
        n_checks++; if (result !== 32'h0000_0100) begin n_fail++; $display("FAIL ign_result got %h want 00000100", result); end
        // Pulse start only across the DONE->IDLE edge.
        start = 1'b1; op = 3'd1; data_in = 32'hCAFE_0000; shift_amt = 5'd2;
        tick();
        start = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ign_done_start_busy got %b want 0", busy); end
        tick();
        n_checks++; if (busy !== 1'b0 || result !== 32'h0000_0100) begin n_fail++; $display("FAIL ign_done_start_idle got busy=%b result=%h want 0 00000100", busy, result); end
    endtask

    task automatic test_back_to_back();
        int lat;
        start = 1'b1; op = 3'd0; data_in = 32'h0000_0001; shift_amt = 5'd2;
        tick();
        lat = 1;
        while (done !== 1'b1 && lat < 64) begin tick(); lat++; end
        n_checks++; if (lat != 3 || result !== 32'h0000_0004) begin n_fail++; $display("FAIL b2b_first got lat=%0d result=%h want 3 00000004", lat, result); end
        op = 3'd4; data_in = 32'h0000_0003; shift_amt = 5'd1;
        tick();
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got busy=%b done=%b want 0 0", busy, done); end
        tick();
        start = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accepted got busy=%b want 1", busy); end
        lat = 1;
        while (done !== 1'b1 && lat < 64) begin tick(); lat++; end
        n_checks++; if (lat != 2 || result !== 32'h0000_0006) begin n_fail++; $display("FAIL b2b_second got lat=%0d result=%h want 2 00000006", lat, result); end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [31:0] r; int lat, bc, seen;
        start = 1'b1; op = 3'd1; data_in = 32'hFFFF_FFFF; shift_amt = 5'd20;
        tick();
        start = 1'b0;
        for (int i = 1; i < 6; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin n_fail++; $display("FAIL rst_mid got busy=%b done=%b result=%h want 0 0 00000000", busy, done, result); end
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        n_checks++; if (seen != 0) begin n_fail++; $display("FAIL rst_mid_quiet got %0d active cycles want 0", seen); end
        run_op(3'd1, 32'h0000_00F0, 5'd4, r, lat, bc);
        n_checks++; if (r !== 32'h0000_000F || lat != 5) begin n_fail++; $display("FAIL rst_fresh got result=%h lat=%0d want 0000000f 5", r, lat); end
        tick();
    endtask

    initial begin
        test_reset();
        test_sll();
        test_sra_srl();
        test_rotate();
        test_zero_and_pass();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
